lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/milano_pkg.sv | 47 ++++
 rtl/lsu_load_align.sv | 27 ++
 rtl/lsu.sv | 122 ++++++++++++
 3 files changed

// File: rtl/milano_pkg.sv
// Shared types for the milano core: LSU operation codes, LSU FSM states
// and small helpers that decode access width from an operation.
package milano_pkg;

   typedef enum logic [3:0] {
      LSU_NONE = 4'd0,
      LSU_LB   = 4'd1,
      LSU_LH   = 4'd2,
      LSU_LW   = 4'd3,
      LSU_LBU  = 4'd4,
      LSU_LHU  = 4'd5,
      LSU_SB   = 4'd6,
      LSU_SH   = 4'd7,
      LSU_SW   = 4'd8
   } lsu_opt_e;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      REQ         = 2'd1,
      WAIT_RVALID = 2'd2
   } lsu_state_e;

   function automatic logic lsu_misaligned(input lsu_opt_e op, input logic [1:0] a);
      logic mis;
      mis = 1'b0;
      case (op)
         LSU_LH, LSU_LHU, LSU_SH: mis = a[0];
         LSU_LW, LSU_SW:          mis = |a;
         default:                 mis = 1'b0;
      endcase
      return mis;
   endfunction

   // Loads and stores of the same width share the same byte-lane pattern.
   function automatic logic [3:0] lsu_be(input lsu_opt_e op, input logic [1:0] a);
      logic [3:0] be;
      be = 4'b0000;
      case (op)
         LSU_LB, LSU_LBU, LSU_SB: be = 4'b0001 << a;
         LSU_LH, LSU_LHU, LSU_SH: be = 4'b0011 << a;
         LSU_LW, LSU_SW:          be = 4'b1111;
         default:                 be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load formatter: moves the addressed byte/half to bit 0
// and sign- or zero-extends it according to the load operation.
module lsu_load_align
   import milano_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  addr_i,
   input  lsu_opt_e    op_i,
   output logic [31:0] result_o
);

   logic [31:0] shifted;

   assign shifted = rdata_i >> {addr_i, 3'b000};

   always_comb begin
      result_o = shifted;
      case (op_i)
         LSU_LB:  result_o = {{24{shifted[7]}}, shifted[7:0]};
         LSU_LBU: result_o = {24'h000000, shifted[7:0]};
         LSU_LH:  result_o = {{16{shifted[15]}}, shifted[15:0]};
         LSU_LHU: result_o = {16'h0000, shifted[15:0]};
         default: result_o = shifted;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding data-bus transaction at a time,
// misalignment trapped locally without touching the bus.
module lsu
   import milano_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        lsu_req_i,
   input  logic        lsu_we_i,
   input  lsu_opt_e    lsu_operate_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_wdata_i,
   output logic        lsu_busy_o,
   output logic        lsu_valid_o,
   output logic [31:0] lsu_rdata_o,
   output logic        lsu_err_o,
   output logic        data_req_o,
   input  logic        data_gnt_i,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_addr_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_rvalid_i,
   input  logic [31:0] data_rdata_i,
   input  logic        data_err_i
);

   lsu_state_e  state_reg, state_next;
   lsu_opt_e    op_reg;
   logic        we_reg;
   logic [31:0] addr_reg;
   logic [31:0] wdata_reg;
   logic        valid_reg;
   logic        err_reg;
   logic [31:0] rdata_reg;

   logic        latch_en;
   logic        mis_pulse;
   logic        done;
   logic [31:0] load_result;

   lsu_load_align u_load_align (
      .rdata_i  (data_rdata_i),
      .addr_i   (addr_reg[1:0]),
      .op_i     (op_reg),
      .result_o (load_result)
   );

   always_comb begin
      state_next = state_reg;
      latch_en   = 1'b0;
      mis_pulse  = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (lsu_req_i && (lsu_operate_i != LSU_NONE)) begin
               latch_en = 1'b1;
               if (lsu_misaligned(lsu_operate_i, lsu_addr_i[1:0])) begin
                  mis_pulse = 1'b1;
               end else begin
                  state_next = REQ;
               end
            end
         end
         REQ: begin
            if (data_gnt_i) state_next = WAIT_RVALID;
         end
         WAIT_RVALID: begin
            if (data_rvalid_i) begin
               done       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg <= IDLE;
         op_reg    <= LSU_NONE;
         we_reg    <= 1'b0;
         addr_reg  <= '0;
         wdata_reg <= '0;
         valid_reg <= 1'b0;
         err_reg   <= 1'b0;
         rdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (latch_en) begin
            op_reg    <= lsu_operate_i;
            we_reg    <= lsu_we_i;
            addr_reg  <= lsu_addr_i;
            wdata_reg <= lsu_wdata_i;
         end
         valid_reg <= mis_pulse | done;
         err_reg   <= mis_pulse | (done & data_err_i);
         // Stores and failed accesses return zero rather than bus data.
         rdata_reg <= (done && !data_err_i && !we_reg) ? load_result : '0;
      end
   end

   always_comb begin
      data_wdata_o = wdata_reg;
      case (op_reg)
         LSU_SB:  data_wdata_o = {4{wdata_reg[7:0]}};
         LSU_SH:  data_wdata_o = {2{wdata_reg[15:0]}};
         default: data_wdata_o = wdata_reg;
      endcase
   end

   assign data_req_o  = (state_reg == REQ);
   assign data_we_o   = we_reg;
   assign data_be_o   = lsu_be(op_reg, addr_reg[1:0]);
   assign data_addr_o = {addr_reg[31:2], 2'b00};

   assign lsu_busy_o  = (state_reg != IDLE);
   assign lsu_valid_o = valid_reg;
   assign lsu_err_o   = err_reg;
   assign lsu_rdata_o = rdata_reg;

endmodule
